// File: rtl/issue_dispatch.sv
// Dual-slot in-order issue stage: holds one decoded pair, checks sources against a
// latency-countdown scoreboard, and dispatches each slot to its even or odd pipe.
module issue_dispatch (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        s0_v,
    input  logic [31:0] s0_full_instr,
    input  logic [6:0]  s0_instr_id,
    input  logic [6:0]  s0_reg_dst,
    input  logic [2:0]  s0_unit_id,
    input  logic [3:0]  s0_latency,
    input  logic        s0_reg_wr,
    input  logic [6:0]  s0_ra_addr,
    input  logic [6:0]  s0_rb_addr,
    input  logic [6:0]  s0_rc_addr,
    input  logic [2:0]  s0_src_used,
    input  logic        s0_pipe,
    input  logic        s1_v,
    input  logic [31:0] s1_full_instr,
    input  logic [6:0]  s1_instr_id,
    input  logic [6:0]  s1_reg_dst,
    input  logic [2:0]  s1_unit_id,
    input  logic [3:0]  s1_latency,
    input  logic        s1_reg_wr,
    input  logic [6:0]  s1_ra_addr,
    input  logic [6:0]  s1_rb_addr,
    input  logic [6:0]  s1_rc_addr,
    input  logic [2:0]  s1_src_used,
    input  logic        s1_pipe,
    output logic [31:0] even_full_instr,
    output logic [6:0]  even_instr_id,
    output logic [6:0]  even_reg_dst,
    output logic [2:0]  even_unit_id,
    output logic [3:0]  even_latency,
    output logic        even_reg_wr,
    output logic [6:0]  even_ra_addr,
    output logic [6:0]  even_rb_addr,
    output logic [6:0]  even_rc_addr,
    output logic        even_valid,
    output logic [31:0] odd_full_instr,
    output logic [6:0]  odd_instr_id,
    output logic [6:0]  odd_reg_dst,
    output logic [2:0]  odd_unit_id,
    output logic [3:0]  odd_latency,
    output logic        odd_reg_wr,
    output logic [6:0]  odd_ra_addr,
    output logic [6:0]  odd_rb_addr,
    output logic [6:0]  odd_rc_addr,
    output logic        odd_valid,
    output logic [15:0] stall_cnt
);

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned ID_W     = 7;
    localparam int unsigned REG_W    = 7;
    localparam int unsigned UNIT_W   = 3;
    localparam int unsigned LAT_W    = 4;
    localparam int unsigned SRC_W    = 3;
    localparam int unsigned NUM_REGS = 128;
    localparam int unsigned STALL_W  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD2 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] full_instr;
        logic [ID_W-1:0]    instr_id;
        logic [REG_W-1:0]   reg_dst;
        logic [UNIT_W-1:0]  unit_id;
        logic [LAT_W-1:0]   latency;
        logic               reg_wr;
        logic [REG_W-1:0]   ra_addr;
        logic [REG_W-1:0]   rb_addr;
        logic [REG_W-1:0]   rc_addr;
        logic [SRC_W-1:0]   src_used;
        logic               pipe;
    } slot_t;

    typedef struct packed {
        logic [INSTR_W-1:0] full_instr;
        logic [ID_W-1:0]    instr_id;
        logic [REG_W-1:0]   reg_dst;
        logic [UNIT_W-1:0]  unit_id;
        logic [LAT_W-1:0]   latency;
        logic               reg_wr;
        logic [REG_W-1:0]   ra_addr;
        logic [REG_W-1:0]   rb_addr;
        logic [REG_W-1:0]   rc_addr;
        logic               valid;
    } bundle_t;

    state_t             state_q, state_d;
    slot_t              slot0_q, slot0_d;
    slot_t              slot1_q, slot1_d;
    logic               s1_v_q, s1_v_d;
    bundle_t            even_q, even_d;
    bundle_t            odd_q, odd_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [LAT_W-1:0]   sb_q [NUM_REGS];
    logic [LAT_W-1:0]   sb_d [NUM_REGS];

    slot_t s0_in, s1_in;
    logic  accept_c;
    logic  haz0_c, haz1_c, raw_c, waw_c;
    logic  issue0_c, issue1_c;

    function automatic bundle_t to_bundle(input slot_t s);
        bundle_t b;
        b.full_instr = s.full_instr;
        b.instr_id   = s.instr_id;
        b.reg_dst    = s.reg_dst;
        b.unit_id    = s.unit_id;
        b.latency    = s.latency;
        b.reg_wr     = s.reg_wr;
        b.ra_addr    = s.ra_addr;
        b.rb_addr    = s.rb_addr;
        b.rc_addr    = s.rc_addr;
        b.valid      = 1'b1;
        return b;
    endfunction

    // True when slot s reads register r through any of its used source ports.
    function automatic logic reads_reg(input slot_t s, input logic [REG_W-1:0] r);
        return (s.src_used[2] && (s.ra_addr == r)) ||
               (s.src_used[1] && (s.rb_addr == r)) ||
               (s.src_used[0] && (s.rc_addr == r));
    endfunction

    assign s0_in = '{full_instr: s0_full_instr, instr_id: s0_instr_id, reg_dst: s0_reg_dst,
                     unit_id: s0_unit_id, latency: s0_latency, reg_wr: s0_reg_wr,
                     ra_addr: s0_ra_addr, rb_addr: s0_rb_addr, rc_addr: s0_rc_addr,
                     src_used: s0_src_used, pipe: s0_pipe};
    assign s1_in = '{full_instr: s1_full_instr, instr_id: s1_instr_id, reg_dst: s1_reg_dst,
                     unit_id: s1_unit_id, latency: s1_latency, reg_wr: s1_reg_wr,
                     ra_addr: s1_ra_addr, rb_addr: s1_rb_addr, rc_addr: s1_rc_addr,
                     src_used: s1_src_used, pipe: s1_pipe};

    assign in_ready = (state_q == EMPTY) && !rst && !flush;
    assign accept_c = in_valid && in_ready;

    // Scoreboard source hazards plus intra-pair RAW/WAW checks for co-issue.
    assign haz0_c = (slot0_q.src_used[2] && (sb_q[slot0_q.ra_addr] != '0)) ||
                    (slot0_q.src_used[1] && (sb_q[slot0_q.rb_addr] != '0)) ||
                    (slot0_q.src_used[0] && (sb_q[slot0_q.rc_addr] != '0));
    assign haz1_c = (slot1_q.src_used[2] && (sb_q[slot1_q.ra_addr] != '0)) ||
                    (slot1_q.src_used[1] && (sb_q[slot1_q.rb_addr] != '0)) ||
                    (slot1_q.src_used[0] && (sb_q[slot1_q.rc_addr] != '0));
    assign raw_c  = slot0_q.reg_wr && reads_reg(slot1_q, slot0_q.reg_dst);
    assign waw_c  = slot0_q.reg_wr && slot1_q.reg_wr && (slot0_q.reg_dst == slot1_q.reg_dst);

    always_comb begin
        state_d  = state_q;
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        s1_v_d   = s1_v_q;
        issue0_c = 1'b0;
        issue1_c = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    slot0_d = s0_in;
                    slot1_d = s1_in;
                    s1_v_d  = s1_v;
                    if (s0_v) begin
                        state_d = HOLD2;
                    end else if (s1_v) begin
                        state_d = HOLD1;
                    end
                end
            end
            HOLD2: begin
                if (!flush) begin
                    issue0_c = !haz0_c;
                    issue1_c = issue0_c && s1_v_q && (slot1_q.pipe != slot0_q.pipe) &&
                               !haz1_c && !raw_c && !waw_c;
                    if (issue0_c) begin
                        state_d = (issue1_c || !s1_v_q) ? EMPTY : HOLD1;
                    end
                end
            end
            HOLD1: begin
                if (!flush) begin
                    issue1_c = !haz1_c;
                    if (issue1_c) begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // Issue bundles, stall counter and scoreboard update.
    always_comb begin
        even_d  = '0;
        odd_d   = '0;
        stall_d = stall_q;
        if (issue0_c) begin
            if (slot0_q.pipe) odd_d  = to_bundle(slot0_q);
            else              even_d = to_bundle(slot0_q);
        end
        if (issue1_c) begin
            if (slot1_q.pipe) odd_d  = to_bundle(slot1_q);
            else              even_d = to_bundle(slot1_q);
        end
        if ((state_q != EMPTY) && !flush && !issue0_c && !issue1_c && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_d[i] = (sb_q[i] != '0) ? (sb_q[i] - LAT_W'(1)) : '0;
        end
        if (issue0_c && slot0_q.reg_wr) begin
            sb_d[slot0_q.reg_dst] = slot0_q.latency;
        end
        if (issue1_c && slot1_q.reg_wr) begin
            sb_d[slot1_q.reg_dst] = slot1_q.latency;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
            s1_v_q  <= 1'b0;
            even_q  <= '0;
            odd_q   <= '0;
            stall_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            s1_v_q  <= s1_v_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
            stall_q <= stall_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign even_full_instr = even_q.full_instr;
    assign even_instr_id   = even_q.instr_id;
    assign even_reg_dst    = even_q.reg_dst;
    assign even_unit_id    = even_q.unit_id;
    assign even_latency    = even_q.latency;
    assign even_reg_wr     = even_q.reg_wr;
    assign even_ra_addr    = even_q.ra_addr;
    assign even_rb_addr    = even_q.rb_addr;
    assign even_rc_addr    = even_q.rc_addr;
    assign even_valid      = even_q.valid;
    assign odd_full_instr  = odd_q.full_instr;
    assign odd_instr_id    = odd_q.instr_id;
    assign odd_reg_dst     = odd_q.reg_dst;
    assign odd_unit_id     = odd_q.unit_id;
    assign odd_latency     = odd_q.latency;
    assign odd_reg_wr      = odd_q.reg_wr;
    assign odd_ra_addr     = odd_q.ra_addr;
    assign odd_rb_addr     = odd_q.rb_addr;
    assign odd_rc_addr     = odd_q.rc_addr;
    assign odd_valid       = odd_q.valid;
    assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_issue_dispatch.sv
// Bench for issue_dispatch: directed cycle table for the corner cases, then random
// traffic against a queue/ready-time reference model.
module tb_issue_dispatch;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush;
    logic        s0_v, s0_reg_wr, s0_pipe, s1_v, s1_reg_wr, s1_pipe;
    logic [31:0] s0_full_instr, s1_full_instr;
    logic [6:0]  s0_instr_id, s0_reg_dst, s0_ra_addr, s0_rb_addr, s0_rc_addr;
    logic [6:0]  s1_instr_id, s1_reg_dst, s1_ra_addr, s1_rb_addr, s1_rc_addr;
    logic [2:0]  s0_unit_id, s0_src_used, s1_unit_id, s1_src_used;
    logic [3:0]  s0_latency, s1_latency;
    logic [31:0] even_full_instr, odd_full_instr;
    logic [6:0]  even_instr_id, even_reg_dst, even_ra_addr, even_rb_addr, even_rc_addr;
    logic [6:0]  odd_instr_id, odd_reg_dst, odd_ra_addr, odd_rb_addr, odd_rc_addr;
    logic [2:0]  even_unit_id, odd_unit_id;
    logic [3:0]  even_latency, odd_latency;
    logic        even_reg_wr, even_valid, odd_reg_wr, odd_valid;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    issue_dispatch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .s0_v(s0_v), .s0_full_instr(s0_full_instr), .s0_instr_id(s0_instr_id),
        .s0_reg_dst(s0_reg_dst), .s0_unit_id(s0_unit_id), .s0_latency(s0_latency),
        .s0_reg_wr(s0_reg_wr), .s0_ra_addr(s0_ra_addr), .s0_rb_addr(s0_rb_addr),
        .s0_rc_addr(s0_rc_addr), .s0_src_used(s0_src_used), .s0_pipe(s0_pipe),
        .s1_v(s1_v), .s1_full_instr(s1_full_instr), .s1_instr_id(s1_instr_id),
        .s1_reg_dst(s1_reg_dst), .s1_unit_id(s1_unit_id), .s1_latency(s1_latency),
        .s1_reg_wr(s1_reg_wr), .s1_ra_addr(s1_ra_addr), .s1_rb_addr(s1_rb_addr),
        .s1_rc_addr(s1_rc_addr), .s1_src_used(s1_src_used), .s1_pipe(s1_pipe),
        .even_full_instr(even_full_instr), .even_instr_id(even_instr_id),
        .even_reg_dst(even_reg_dst), .even_unit_id(even_unit_id), .even_latency(even_latency),
        .even_reg_wr(even_reg_wr), .even_ra_addr(even_ra_addr), .even_rb_addr(even_rb_addr),
        .even_rc_addr(even_rc_addr), .even_valid(even_valid),
        .odd_full_instr(odd_full_instr), .odd_instr_id(odd_instr_id),
        .odd_reg_dst(odd_reg_dst), .odd_unit_id(odd_unit_id), .odd_latency(odd_latency),
        .odd_reg_wr(odd_reg_wr), .odd_ra_addr(odd_ra_addr), .odd_rb_addr(odd_rb_addr),
        .odd_rc_addr(odd_rc_addr), .odd_valid(odd_valid),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit        v;
        bit [31:0] full;
        bit [6:0]  id;
        bit [6:0]  dst;
        bit [2:0]  unit;
        bit [3:0]  lat;
        bit        wr;
        bit [6:0]  ra, rb, rc;
        bit [2:0]  used;
        bit        pipe;
    } tslot_t;

    typedef struct {
        bit     rst, flush, inv;
        tslot_t a, b;
        bit     rdy, ev, od;
        int     edst, odst, stall;
    } vec_t;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    vec_t   tbl[$];
    tslot_t ns;

    // Reference model: pending slots in program order; register ready time in cycles.
    tslot_t      pend[$];
    int          ready_at[128];
    int          ncyc = 0;
    int          m_stall = 0;
    logic [75:0] m_even, m_odd;

    task automatic chk(string nm, logic [75:0] act, logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic tslot_t mk(bit v, bit pipe, int dst, bit wr, int lat, int ra, int rb,
                                  bit [2:0] used);
        tslot_t s;
        s.v    = v;
        s.pipe = pipe;
        s.dst  = 7'(dst);
        s.wr   = wr;
        s.lat  = 4'(lat);
        s.ra   = 7'(ra);
        s.rb   = 7'(rb);
        s.rc   = 7'd0;
        s.used = used;
        s.full = 32'h1000_0000 + 32'(dst);
        s.id   = 7'(dst + 1);
        s.unit = pipe ? 3'd3 : 3'd1;
        return s;
    endfunction

    function automatic tslot_t rnd_slot();
        tslot_t s;
        s.v    = ($urandom_range(0, 9) != 0);
        s.pipe = 1'($urandom_range(0, 1));
        s.dst  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
        s.wr   = ($urandom_range(0, 3) != 0);
        s.lat  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        s.ra   = 7'($urandom_range(0, 7));
        s.rb   = 7'($urandom_range(0, 7));
        s.rc   = 7'($urandom_range(0, 7));
        s.used = 3'($urandom_range(0, 7));
        s.full = 32'($urandom);
        s.id   = 7'($urandom);
        s.unit = 3'($urandom);
        return s;
    endfunction

    function automatic logic [75:0] bundle_of(tslot_t s);
        return {s.full, s.id, s.dst, s.unit, s.lat, s.wr, s.ra, s.rb, s.rc, 1'b1};
    endfunction

    function automatic logic [75:0] dut_even();
        return {even_full_instr, even_instr_id, even_reg_dst, even_unit_id, even_latency,
                even_reg_wr, even_ra_addr, even_rb_addr, even_rc_addr, even_valid};
    endfunction

    function automatic logic [75:0] dut_odd();
        return {odd_full_instr, odd_instr_id, odd_reg_dst, odd_unit_id, odd_latency,
                odd_reg_wr, odd_ra_addr, odd_rb_addr, odd_rc_addr, odd_valid};
    endfunction

    function automatic bit m_clear(tslot_t s);
        if (s.used[2] && (ncyc < ready_at[s.ra])) return 1'b0;
        if (s.used[1] && (ncyc < ready_at[s.rb])) return 1'b0;
        if (s.used[0] && (ncyc < ready_at[s.rc])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_reads(tslot_t s, bit [6:0] r);
        return (s.used[2] && s.ra == r) || (s.used[1] && s.rb == r) || (s.used[0] && s.rc == r);
    endfunction

    task automatic m_place(tslot_t s);
        if (s.pipe) m_odd = bundle_of(s);
        else        m_even = bundle_of(s);
        if (s.wr) ready_at[s.dst] = ncyc + 1 + int'(s.lat);
    endtask

    task automatic m_step(bit r, bit f, bit iv, tslot_t a, tslot_t b);
        bit     i0, i1;
        tslot_t h0, h1;
        m_even = '0;
        m_odd  = '0;
        if (r) begin
            pend.delete();
            foreach (ready_at[k]) ready_at[k] = 0;
            m_stall = 0;
        end else if (f) begin
            pend.delete();
        end else if (pend.size() == 0) begin
            if (iv) begin
                if (a.v) pend.push_back(a);
                if (b.v) pend.push_back(b);
            end
        end else begin
            h0 = pend[0];
            i0 = m_clear(h0);
            i1 = 1'b0;
            if (i0 && pend.size() == 2) begin
                h1 = pend[1];
                i1 = (h1.pipe != h0.pipe) && m_clear(h1) && !(h0.wr && m_reads(h1, h0.dst)) &&
                     !(h0.wr && h1.wr && h0.dst == h1.dst);
            end
            if (i0) begin
                m_place(h0);
                void'(pend.pop_front());
            end
            if (i1) begin
                m_place(h1);
                void'(pend.pop_front());
            end
            if (!i0 && m_stall < 65535) m_stall++;
        end
        ncyc++;
    endtask

    task automatic drive(bit r, bit f, bit iv, tslot_t a, tslot_t b);
        rst = r; flush = f; in_valid = iv;
        s0_v = a.v; s0_full_instr = a.full; s0_instr_id = a.id; s0_reg_dst = a.dst;
        s0_unit_id = a.unit; s0_latency = a.lat; s0_reg_wr = a.wr; s0_ra_addr = a.ra;
        s0_rb_addr = a.rb; s0_rc_addr = a.rc; s0_src_used = a.used; s0_pipe = a.pipe;
        s1_v = b.v; s1_full_instr = b.full; s1_instr_id = b.id; s1_reg_dst = b.dst;
        s1_unit_id = b.unit; s1_latency = b.lat; s1_reg_wr = b.wr; s1_ra_addr = b.ra;
        s1_rb_addr = b.rb; s1_rc_addr = b.rc; s1_src_used = b.used; s1_pipe = b.pipe;
    endtask

    task automatic add(bit r, bit f, bit iv, tslot_t a, tslot_t b, bit rdy, bit ev, bit od,
                       int edst, int odst, int stall);
        vec_t v;
        v.rst = r; v.flush = f; v.inv = iv; v.a = a; v.b = b;
        v.rdy = rdy; v.ev = ev; v.od = od; v.edst = edst; v.odst = odst; v.stall = stall;
        tbl.push_back(v);
    endtask

    initial begin
        tslot_t a0, a1, b0, b1, c0, c1, d0, e0, f0, f1, g0, g1, j0, h0, h1, k0;
        tslot_t ra, rb;
        bit     rr, rf, riv;

        ns = mk(0, 0, 0, 0, 0, 0, 0, 3'b000);
        a0 = mk(1, 0, 3, 1, 2, 1, 2, 3'b110);
        a1 = mk(1, 1, 4, 1, 6, 9, 0, 3'b100);
        b0 = mk(1, 0, 7, 1, 1, 1, 0, 3'b100);
        b1 = mk(1, 0, 8, 1, 1, 2, 0, 3'b100);
        c0 = mk(1, 0, 5, 1, 0, 1, 0, 3'b100);
        c1 = mk(1, 1, 6, 1, 1, 5, 0, 3'b100);
        d0 = mk(1, 0, 5, 1, 6, 1, 0, 3'b100);
        e0 = mk(1, 1, 9, 1, 1, 5, 0, 3'b100);
        f0 = mk(1, 0, 10, 1, 1, 0, 0, 3'b000);
        f1 = mk(1, 0, 11, 1, 1, 0, 0, 3'b000);
        g0 = mk(1, 0, 12, 1, 0, 0, 0, 3'b000);
        g1 = mk(1, 1, 13, 1, 0, 0, 0, 3'b000);
        j0 = mk(1, 0, 20, 1, 15, 0, 0, 3'b000);
        h0 = mk(1, 0, 12, 1, 5, 20, 0, 3'b100);
        h1 = mk(1, 1, 13, 1, 1, 0, 0, 3'b000);
        k0 = mk(1, 0, 14, 1, 1, 20, 0, 3'b100);

        //  rst flush inv  s0  s1   rdy ev od edst odst stall
        add(1, 0, 0, ns, ns,   0, 0, 0, 0, 0, 0);
        add(0, 0, 1, a0, a1,   1, 0, 0, 0, 0, 0);   // independent pair co-issues
        add(0, 0, 0, ns, ns,   0, 1, 1, 3, 4, 0);
        add(0, 0, 0, ns, ns,   1, 0, 0, 0, 0, 0);
        add(0, 0, 1, b0, b1,   1, 0, 0, 0, 0, 0);   // both even: serialised
        add(0, 0, 0, ns, ns,   0, 1, 0, 7, 0, 0);
        add(0, 0, 0, ns, ns,   0, 1, 0, 8, 0, 0);
        add(0, 0, 0, ns, ns,   1, 0, 0, 0, 0, 0);
        add(0, 0, 1, c0, c1,   1, 0, 0, 0, 0, 0);   // intra-pair RAW, latency 0 writer
        add(0, 0, 0, ns, ns,   0, 1, 0, 5, 0, 0);
        add(0, 0, 0, ns, ns,   0, 0, 1, 0, 6, 0);
        add(0, 0, 0, ns, ns,   1, 0, 0, 0, 0, 0);
        add(0, 0, 1, d0, ns,   1, 0, 0, 0, 0, 0);   // latency-6 producer then consumer
        add(0, 0, 0, ns, ns,   0, 1, 0, 5, 0, 0);
        add(0, 0, 1, e0, ns,   1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, ns, ns, 0, 0, 0, 0, 0, i);
        add(0, 0, 0, ns, ns,   0, 0, 1, 0, 9, 5);
        add(0, 0, 1, f0, f1,   1, 0, 0, 0, 0, 5);   // flush in HOLD1
        add(0, 0, 0, ns, ns,   0, 1, 0, 10, 0, 5);
        add(0, 1, 0, ns, ns,   0, 0, 0, 0, 0, 5);
        add(0, 1, 1, g0, g1,   0, 0, 0, 0, 0, 5);   // flush blocks accept
        add(0, 0, 0, ns, ns,   1, 0, 0, 0, 0, 5);
        add(0, 0, 1, j0, ns,   1, 0, 0, 0, 0, 5);   // reset while HOLD2 on a hazard
        add(0, 0, 0, ns, ns,   0, 1, 0, 20, 0, 5);
        add(0, 0, 1, h0, h1,   1, 0, 0, 0, 0, 5);
        add(0, 0, 0, ns, ns,   0, 0, 0, 0, 0, 6);
        add(1, 0, 0, ns, ns,   0, 0, 0, 0, 0, 0);
        add(0, 0, 1, k0, ns,   1, 0, 0, 0, 0, 0);
        add(0, 0, 0, ns, ns,   0, 1, 0, 14, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].flush, tbl[i].inv, tbl[i].a, tbl[i].b);
            #1;
            chk("tbl_in_ready", 76'(in_ready), 76'(tbl[i].rdy));
            @(posedge clk);
            #1;
            cyc++;
            chk("tbl_even_valid", 76'(even_valid), 76'(tbl[i].ev));
            chk("tbl_odd_valid", 76'(odd_valid), 76'(tbl[i].od));
            chk("tbl_even_dst", 76'(even_reg_dst), 76'(tbl[i].edst));
            chk("tbl_odd_dst", 76'(odd_reg_dst), 76'(tbl[i].odst));
            chk("tbl_stall", 76'(stall_cnt), 76'(tbl[i].stall));
        end

        for (int n = 0; n < 4000; n++) begin
            rr  = (n == 0) || ($urandom_range(0, 299) == 0);
            rf  = ($urandom_range(0, 24) == 0);
            riv = ($urandom_range(0, 3) != 0);
            ra  = rnd_slot();
            rb  = rnd_slot();
            @(negedge clk);
            drive(rr, rf, riv, ra, rb);
            #1;
            chk("rnd_in_ready", 76'(in_ready), 76'(pend.size() == 0 && !rr && !rf));
            m_step(rr, rf, riv, ra, rb);
            @(posedge clk);
            #1;
            cyc++;
            chk("rnd_even_bundle", dut_even(), m_even);
            chk("rnd_odd_bundle", dut_odd(), m_odd);
            chk("rnd_stall", 76'(stall_cnt), 76'(m_stall));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_dispatch.md
ISSUE_DISPATCH -- requirements
Module: issue_dispatch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; every output SHALL reset to zero.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  decoded instruction pair offered by ID.
REQ-005 in_ready  output  1  pair accepted on edge where in_valid & in_ready.
REQ-006 flush  input  1  taken branch; discard held, un-issued slots.
REQ-007 s0_v, s1_v  input  1 each  slot valid (s0 is older in program order).
REQ-008 sN_full_instr [0:31], sN_instr_id [0:6], sN_reg_dst [0:6], sN_unit_id [0:2], sN_latency [0:3], sN_reg_wr [0:0]  input  per slot N=0,1  decoded fields.
REQ-009 sN_ra_addr, sN_rb_addr, sN_rc_addr [0:6], sN_src_used [0:2]  input  per slot  source addresses; src_used bits = {ra,rb,rc} actually read.
REQ-010 sN_pipe  input  1  per slot; 0 = even pipe, 1 = odd pipe.
REQ-011 even_* / odd_*  output  full_instr 32, instr_id 7, reg_dst 7, unit_id 3, latency 4, reg_wr 1, ra/rb/rc_addr 7  registered issue bundle per pipe.
REQ-012 even_valid, odd_valid  output  1  bundle holds a real instruction this cycle.
REQ-013 stall_cnt  output  16  saturating count of hazard-stall cycles.

Function
REQ-014 FSM states SHALL be EMPTY, HOLD2 (s0 and s1 pending), HOLD1 (only s1 pending); reset state EMPTY.
REQ-015 in_ready SHALL equal (state==EMPTY) & !rst & !flush.
REQ-016 On accept: latch both slots; go HOLD2 if s0_v, else HOLD1 if s1_v, else stay EMPTY.
REQ-017 Scoreboard: 128 entries x 4-bit countdown; source hazard for slot when any used source has entry != 0.
REQ-018 On issue with reg_wr=1, entry[reg_dst] SHALL load latency; all other nonzero entries decrement by 1 each cycle; load wins over decrement on same entry.
REQ-019 HOLD2: s0 issues iff no s0 hazard; s1 co-issues iff s0 issues, s1_pipe != s0_pipe, no s1 hazard, no s1 used source equal to s0_reg_dst when s0_reg_wr, and not (both reg_wr with equal reg_dst).
REQ-020 HOLD2 transitions: both issue -> EMPTY; s0 only -> HOLD1 (or EMPTY if s1 invalid); none -> HOLD2.
REQ-021 HOLD1: s1 issues iff no s1 hazard -> EMPTY, else stay.
REQ-022 Slot N issue SHALL drive the pipe selected by sN_pipe on the next edge, with that pipe's valid=1; s1 never issues before s0.
REQ-023 Pipe with no issue in a cycle SHALL present all-zero bundle and valid=0 (reg_wr=0 bubble).
REQ-024 stall_cnt SHALL increment once per cycle in HOLD2/HOLD1 with no issue, saturating at 0xFFFF.
REQ-025 Latency 0 with reg_wr=1 SHALL leave entry at 0 (no stall).
REQ-026 flush: next state EMPTY, held slots dropped, no issue that cycle, outputs zero next cycle; scoreboard keeps counting.
REQ-027 rst has priority over flush and accept.

Reset
REQ-028 After rst: state EMPTY, scoreboard all zero, bundles/valids zero, stall_cnt 0, in_ready 0 while rst high, 1 first cycle after.
REQ-029 Reset mid-HOLD SHALL discard held slots without issuing them.

Verification
REQ-030 Independent pair s0 even add r3<-r1,r2 lat 2, s1 odd lqd r4 lat 6 -> both valid on same edge one cycle after accept; in_ready returns high.
REQ-031 Two even slots, independent -> s0 on even_* edge E1, s1 on even_* edge E2; odd_valid stays 0; stall_cnt unchanged.
REQ-032 s0 writes r5, s1 (opposite pipe) reads ra=r5 -> split issue across two edges.
REQ-033 Pair A s0 writes r5 lat 6 issued at E1; pair B reads r5 -> B issues at E8, stall_cnt=5.
REQ-034 flush while in HOLD1 -> s1 never issued, state EMPTY, in_ready 1 next cycle; rst while HOLD2 -> all outputs 0, scoreboard cleared.
